// File: rtl/obi_rr_mem_arbiter.sv
// Two-master OBI arbiter for one memory data port: round-robin grant, address-phase
// locking, and an in-order ID FIFO that steers each rvalid back to its issuing master.
module obi_rr_mem_arbiter #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [1:0]                m_req_i,
   output logic [1:0]                m_gnt_o,
   output logic [1:0]                m_rvalid_o,
   input  logic [2*ADDR_WIDTH-1:0]   m_addr_i,
   input  logic [1:0]                m_we_i,
   input  logic [2*DATA_WIDTH/8-1:0] m_be_i,
   input  logic [2*DATA_WIDTH-1:0]   m_wdata_i,
   output logic [DATA_WIDTH-1:0]     m_rdata_o,
   output logic                      s_req_o,
   input  logic                      s_gnt_i,
   input  logic                      s_rvalid_i,
   output logic [ADDR_WIDTH-1:0]     s_addr_o,
   output logic                      s_we_o,
   output logic [DATA_WIDTH/8-1:0]   s_be_o,
   output logic [DATA_WIDTH-1:0]     s_wdata_o,
   input  logic [DATA_WIDTH-1:0]     s_rdata_i,
   output logic                      err_o
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);

   typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_t;

   lock_state_t                state_q, state_d;
   logic                       lock_id_q, lock_id_d;
   logic                       rr_q;
   logic                       err_q;
   logic [CW-1:0]              count_q;
   logic [PW-1:0]              head_q, tail_q;
   logic [MAX_OUTSTANDING-1:0] ids_q;

   logic       has_room;
   logic [1:0] elig;
   logic       sel, sel_valid, lock_drop;
   logic       push, pop, spurious, head_id;

   // Eligibility is gated by reset so nothing leaks to memory while rst_ni is low.
   always_comb begin
      has_room  = rst_ni && (count_q < CNT_MAX);
      elig      = m_req_i & {2{has_room}};
      sel       = rr_q;
      sel_valid = 1'b0;
      lock_drop = 1'b0;
      if (state_q == ST_LOCKED) begin
         sel       = lock_id_q;
         sel_valid = elig[lock_id_q];
         lock_drop = ~m_req_i[lock_id_q];
      end else begin
         case (elig)
            2'b01:   begin sel = 1'b0; sel_valid = 1'b1; end
            2'b10:   begin sel = 1'b1; sel_valid = 1'b1; end
            2'b11:   begin sel = rr_q; sel_valid = 1'b1; end
            default: ;
         endcase
      end
   end

   always_comb begin
      s_req_o   = sel_valid;
      s_addr_o  = '0;
      s_we_o    = 1'b0;
      s_be_o    = '0;
      s_wdata_o = '0;
      m_gnt_o   = 2'b00;
      if (sel_valid) begin
         if (sel) begin
            s_addr_o  = m_addr_i[ADDR_WIDTH +: ADDR_WIDTH];
            s_we_o    = m_we_i[1];
            s_be_o    = m_be_i[BW +: BW];
            s_wdata_o = m_wdata_i[DATA_WIDTH +: DATA_WIDTH];
         end else begin
            s_addr_o  = m_addr_i[0 +: ADDR_WIDTH];
            s_we_o    = m_we_i[0];
            s_be_o    = m_be_i[0 +: BW];
            s_wdata_o = m_wdata_i[0 +: DATA_WIDTH];
         end
         if (s_gnt_i) m_gnt_o[sel] = 1'b1;
      end
   end

   assign push = s_req_o & s_gnt_i;

   // Lock holds the address phase on one master until memory grants it.
   always_comb begin
      state_d   = state_q;
      lock_id_d = lock_id_q;
      case (state_q)
         ST_OPEN: begin
            if (s_req_o && !s_gnt_i) begin
               state_d   = ST_LOCKED;
               lock_id_d = sel;
            end
         end
         ST_LOCKED: begin
            if (lock_drop || s_gnt_i) state_d = ST_OPEN;
         end
         default: state_d = ST_OPEN;
      endcase
   end

   always_comb begin
      head_id    = ids_q[head_q];
      pop        = s_rvalid_i && (count_q != '0);
      spurious   = s_rvalid_i && (count_q == '0);
      m_rvalid_o = 2'b00;
      if (pop) m_rvalid_o[head_id] = 1'b1;
   end

   assign m_rdata_o = s_rdata_i;
   assign err_o     = err_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_OPEN;
         lock_id_q <= 1'b0;
         rr_q      <= 1'b0;
         err_q     <= 1'b0;
         count_q   <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         ids_q     <= '0;
      end else begin
         state_q   <= state_d;
         lock_id_q <= lock_id_d;
         if (push) rr_q <= ~sel;
         if (spurious || (state_q == ST_LOCKED && lock_drop)) err_q <= 1'b1;
         if (push) begin
            ids_q[tail_q] <= sel;
            tail_q        <= (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
         end
         if (pop) head_q <= (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_obi_rr_mem_arbiter.sv
// Directed bench for obi_rr_mem_arbiter: inputs change 1 ns after the rising edge
// and combinational outputs are sampled 1 ns later, well before the next edge.
module tb_obi_rr_mem_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  m_req;
   logic [1:0]  m_gnt;
   logic [1:0]  m_rvalid;
   logic [63:0] m_addr;
   logic [1:0]  m_we;
   logic [7:0]  m_be;
   logic [63:0] m_wdata;
   logic [31:0] m_rdata;
   logic        s_req;
   logic        s_gnt;
   logic        s_rvalid;
   logic [31:0] s_addr;
   logic        s_we;
   logic [3:0]  s_be;
   logic [31:0] s_wdata;
   logic [31:0] s_rdata;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   obi_rr_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .m_req_i    (m_req),
      .m_gnt_o    (m_gnt),
      .m_rvalid_o (m_rvalid),
      .m_addr_i   (m_addr),
      .m_we_i     (m_we),
      .m_be_i     (m_be),
      .m_wdata_i  (m_wdata),
      .m_rdata_o  (m_rdata),
      .s_req_o    (s_req),
      .s_gnt_i    (s_gnt),
      .s_rvalid_i (s_rvalid),
      .s_addr_o   (s_addr),
      .s_we_o     (s_we),
      .s_be_o     (s_be),
      .s_wdata_o  (s_wdata),
      .s_rdata_i  (s_rdata),
      .err_o      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [31:0] a0,
                        input logic [31:0] a1, input logic gnt, input logic rv,
                        input logic [31:0] rd);
      m_req    = req;
      m_we     = we;
      m_addr   = {a1, a0};
      m_be     = {4'h3, 4'hF};
      m_wdata  = {32'h2222_2222, 32'h1111_1111};
      s_gnt    = gnt;
      s_rvalid = rv;
      s_rdata  = rd;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      drive(2'b11, 2'b00, 32'h10, 32'h20, 1'b1, 1'b1, 32'h1234);
      rst_n = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL reset_s_req: got %b exp 0", s_req); end
      n_cmp++; if (m_gnt !== 2'b00) begin n_bad++; $display("FAIL reset_m_gnt: got %b exp 00", m_gnt); end
      n_cmp++; if (m_rvalid !== 2'b00) begin n_bad++; $display("FAIL reset_m_rvalid: got %b exp 00", m_rvalid); end
      repeat (2) @(posedge clk);
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b exp 0", err); end
      n_cmp++; if (s_addr !== 32'h0) begin n_bad++; $display("FAIL reset_s_addr: got %h exp 0", s_addr); end
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      rst_n = 1'b1;
   endtask

   task automatic test_single_read();
      next_cycle();
      drive(2'b01, 2'b00, 32'h100, 32'h0, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (s_req !== 1'b1) begin n_bad++; $display("FAIL single_s_req: got %b exp 1", s_req); end
      n_cmp++; if (s_addr !== 32'h100) begin n_bad++; $display("FAIL single_s_addr: got %h exp 100", s_addr); end
      n_cmp++; if (s_be !== 4'hF) begin n_bad++; $display("FAIL single_s_be: got %h exp f", s_be); end
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL single_m_gnt: got %b exp 01", m_gnt); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
      #1;
      n_cmp++; if (m_rvalid !== 2'b01) begin n_bad++; $display("FAIL single_m_rvalid: got %b exp 01", m_rvalid); end
      n_cmp++; if (m_rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL single_m_rdata: got %h exp deadbeef", m_rdata); end
      n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL single_s_req_idle: got %b exp 0", s_req); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b exp 0", err); end
   endtask

   task automatic test_round_robin();
      logic [1:0]  exp_gnt [4];
      logic [1:0]  exp_rv  [4];
      logic [31:0] exp_addr[4];
      exp_gnt  = '{2'b01, 2'b10, 2'b01, 2'b10};
      exp_rv   = '{2'b00, 2'b01, 2'b10, 2'b01};
      exp_addr = '{32'h10, 32'h20, 32'h10, 32'h20};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         drive(2'b11, 2'b00, 32'h10, 32'h20, 1'b1, (i > 0), 32'hA0 + i);
         #1;
         n_cmp++; if (m_gnt !== exp_gnt[i]) begin n_bad++; $display("FAIL rr_gnt[%0d]: got %b exp %b", i, m_gnt, exp_gnt[i]); end
         n_cmp++; if (m_rvalid !== exp_rv[i]) begin n_bad++; $display("FAIL rr_rvalid[%0d]: got %b exp %b", i, m_rvalid, exp_rv[i]); end
         n_cmp++; if (s_addr !== exp_addr[i]) begin n_bad++; $display("FAIL rr_addr[%0d]: got %h exp %h", i, s_addr, exp_addr[i]); end
      end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'hA4);
      #1;
      n_cmp++; if (m_rvalid !== 2'b10) begin n_bad++; $display("FAIL rr_last_rvalid: got %b exp 10", m_rvalid); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL rr_err: got %b exp 0", err); end
   endtask

   task automatic test_lock();
      do_reset();
      next_cycle();
      drive(2'b10, 2'b10, 32'h300, 32'h200, 1'b0, 1'b0, 0);
      #1;
      n_cmp++; if (s_addr !== 32'h200) begin n_bad++; $display("FAIL lock_addr_c0: got %h exp 200", s_addr); end
      n_cmp++; if (s_we !== 1'b1) begin n_bad++; $display("FAIL lock_we: got %b exp 1", s_we); end
      n_cmp++; if (s_wdata !== 32'h2222_2222) begin n_bad++; $display("FAIL lock_wdata: got %h exp 22222222", s_wdata); end
      n_cmp++; if (s_be !== 4'h3) begin n_bad++; $display("FAIL lock_be: got %h exp 3", s_be); end
      n_cmp++; if (m_gnt !== 2'b00) begin n_bad++; $display("FAIL lock_gnt_c0: got %b exp 00", m_gnt); end
      for (int i = 1; i < 3; i++) begin
         next_cycle();
         drive(2'b11, 2'b10, 32'h300, 32'h200, 1'b0, 1'b0, 0);
         #1;
         n_cmp++; if (s_addr !== 32'h200) begin n_bad++; $display("FAIL lock_addr_c%0d: got %h exp 200", i, s_addr); end
         n_cmp++; if (s_req !== 1'b1) begin n_bad++; $display("FAIL lock_req_c%0d: got %b exp 1", i, s_req); end
      end
      next_cycle();
      drive(2'b11, 2'b10, 32'h300, 32'h200, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (m_gnt !== 2'b10) begin n_bad++; $display("FAIL lock_gnt_m1: got %b exp 10", m_gnt); end
      n_cmp++; if (s_addr !== 32'h200) begin n_bad++; $display("FAIL lock_addr_gnt: got %h exp 200", s_addr); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h300, 32'h200, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL lock_gnt_m0: got %b exp 01", m_gnt); end
      n_cmp++; if (s_addr !== 32'h300) begin n_bad++; $display("FAIL lock_addr_m0: got %h exp 300", s_addr); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'h5);
      #1;
      n_cmp++; if (m_rvalid !== 2'b10) begin n_bad++; $display("FAIL lock_rvalid_m1: got %b exp 10", m_rvalid); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'h6);
      #1;
      n_cmp++; if (m_rvalid !== 2'b01) begin n_bad++; $display("FAIL lock_rvalid_m0: got %b exp 01", m_rvalid); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL lock_err: got %b exp 0", err); end
   endtask

   task automatic test_lock_drop();
      do_reset();
      next_cycle();
      drive(2'b10, 2'b00, 32'h400, 32'h500, 1'b0, 1'b0, 0);
      next_cycle();
      drive(2'b01, 2'b00, 32'h400, 32'h500, 1'b0, 1'b0, 0);
      #1;
      n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL drop_s_req: got %b exp 0", s_req); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h400, 32'h500, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL drop_err: got %b exp 1", err); end
      n_cmp++; if (s_addr !== 32'h400) begin n_bad++; $display("FAIL drop_addr: got %h exp 400", s_addr); end
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL drop_gnt: got %b exp 01", m_gnt); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'h9);
      #1;
      n_cmp++; if (m_rvalid !== 2'b01) begin n_bad++; $display("FAIL drop_rvalid: got %b exp 01", m_rvalid); end
   endtask

   task automatic test_full();
      do_reset();
      next_cycle();
      drive(2'b01, 2'b00, 32'h40, 0, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL full_gnt0: got %b exp 01", m_gnt); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h44, 0, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL full_gnt1: got %b exp 01", m_gnt); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h48, 0, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL full_blocked: got %b exp 0", s_req); end
      n_cmp++; if (m_gnt !== 2'b00) begin n_bad++; $display("FAIL full_gnt_blocked: got %b exp 00", m_gnt); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h48, 0, 1'b1, 1'b1, 32'h111);
      #1;
      n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL full_blocked_pop: got %b exp 0", s_req); end
      n_cmp++; if (m_rvalid !== 2'b01) begin n_bad++; $display("FAIL full_rvalid0: got %b exp 01", m_rvalid); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h48, 0, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (s_req !== 1'b1) begin n_bad++; $display("FAIL full_resume_req: got %b exp 1", s_req); end
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL full_resume_gnt: got %b exp 01", m_gnt); end
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'h200 + i);
         #1;
         n_cmp++; if (m_rvalid !== 2'b01) begin n_bad++; $display("FAIL full_drain[%0d]: got %b exp 01", i, m_rvalid); end
      end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL full_err: got %b exp 0", err); end
   endtask

   task automatic test_spurious();
      do_reset();
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'h55);
      #1;
      n_cmp++; if (m_rvalid !== 2'b00) begin n_bad++; $display("FAIL spur_rvalid: got %b exp 00", m_rvalid); end
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
         #1;
         n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL spur_err_sticky[%0d]: got %b exp 1", i, err); end
      end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL spur_err_reset: got %b exp 0", err); end
      next_cycle();
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid();
      do_reset();
      next_cycle();
      drive(2'b01, 2'b00, 32'h80, 0, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL mid_gnt: got %b exp 01", m_gnt); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h84, 0, 1'b1, 1'b1, 32'h77);
      rst_n = 1'b0;
      #1;
      n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL mid_s_req: got %b exp 0", s_req); end
      n_cmp++; if (m_gnt !== 2'b00) begin n_bad++; $display("FAIL mid_m_gnt: got %b exp 00", m_gnt); end
      n_cmp++; if (m_rvalid !== 2'b00) begin n_bad++; $display("FAIL mid_m_rvalid: got %b exp 00", m_rvalid); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL mid_err: got %b exp 0", err); end
      repeat (2) @(posedge clk);
      #1;
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      rst_n = 1'b1;
      next_cycle();
      drive(2'b01, 2'b00, 32'h90, 0, 1'b1, 1'b0, 0);
      #1;
      n_cmp++; if (m_gnt !== 2'b01) begin n_bad++; $display("FAIL mid_after_gnt: got %b exp 01", m_gnt); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'h99);
      #1;
      n_cmp++; if (m_rvalid !== 2'b01) begin n_bad++; $display("FAIL mid_after_rvalid: got %b exp 01", m_rvalid); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b1, 32'h9A);
      #1;
      n_cmp++; if (m_rvalid !== 2'b00) begin n_bad++; $display("FAIL mid_count_zero: got %b exp 00", m_rvalid); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      #1;
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL mid_spur_err: got %b exp 1", err); end
   endtask

   initial begin
      rst_n = 1'b1;
      drive(2'b00, 2'b00, 0, 0, 1'b0, 1'b0, 0);
      test_reset();
      test_single_read();
      test_round_robin();
      test_lock();
      test_lock_drop();
      test_full();
      test_spurious();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
